// File: rtl/key_code_buffer.sv
// Key-code capture FIFO behind the debounce stage's Key_ready/readn handshake.
// Define KEY_HEX_SHIFT_EN to assemble hex keys into hex_word for the display path.
module key_code_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_ready,
  input  logic [4:0]    key_code,
  output logic          key_readn,
  input  logic          rd_en,
  output logic [4:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [31:0]   hex_word
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_e            state_q;
  logic              readn_q;
  logic [4:0]        mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, rptr_nx;
  logic [AW:0]       count_q, count_d;
  logic              empty_q, full_q, ovf_q, ovf_d;
  logic [4:0]        dout_q, dout_d;
  logic              pop, cap, push, drop;

  // Handshake: one-cycle ack pulse, then wait for key_ready to fall so a held key is taken once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      readn_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (key_ready) begin
          state_q <= S_ACK;
          readn_q <= 1'b0;
        end
        S_ACK: begin
          state_q <= S_WAIT;
          readn_q <= 1'b1;
        end
        S_WAIT: if (!key_ready) state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          readn_q <= 1'b1;
        end
      endcase
    end
  end

  assign rptr_nx = rptr_q + AW'(1);

  always_comb begin
    pop  = rd_en && !empty_q;
    cap  = (state_q == S_IDLE) && key_ready;
    // A pop on the same edge frees the slot a full FIFO would otherwise lack.
    push = cap && (!full_q || pop);
    drop = cap && !push;

    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_nx         : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + ONE_C;
    else if (pop && !push) count_d = count_q - ONE_C;

    // dout is the registered head; it keeps the last value once the FIFO drains.
    dout_d = dout_q;
    if (pop) begin
      if (count_q > ONE_C) dout_d = mem_q[rptr_nx];
      else if (push)       dout_d = key_code;
    end else if (push && empty_q) begin
      dout_d = key_code;
    end

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_C);
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef KEY_HEX_SHIFT_EN
  logic [31:0] hex_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q <= '0;
    end else if (push) begin
      if (key_code[4] == 1'b0)     hex_q <= {hex_q[27:0], key_code[3:0]};
      else if (key_code == 5'h1F)  hex_q <= '0;
    end
  end
  assign hex_word = hex_q;
`else
  assign hex_word = '0;
`endif

  assign key_readn = readn_q;
  assign dout      = dout_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/key_code_buffer.md
Name: key_code_buffer

Overview:
- Downstream consumer of the keypad/switch debounce stage.
- Runs the Key_ready/readn handshake with that stage and captures each 5-bit key code into a DEPTH-entry first-word-fall-through FIFO.
- Presents the codes to a polled reader (CPU/IO bus or display logic) with pop, status and a sticky overflow flag.
- Optionally assembles hex keys into a 32-bit display word for the seven-segment path.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
AW, 3, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
key_ready  in  1  key code valid from debounce stage; held until acknowledged
key_code  in  5  key code from debounce stage; stable while key_ready=1
key_readn  out  1  active-low acknowledge to debounce stage; one-cycle low pulse
rd_en  in  1  pop request from reader
dout  out  5  FIFO head; valid when empty=0
empty  out  1  FIFO empty
full  out  1  FIFO holds DEPTH entries
count  out  AW+1  entries held, 0..DEPTH
overflow  out  1  sticky: a key was acknowledged but dropped
clr_ovf  in  1  clears overflow
hex_word  out  32  assembled hex digits (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, key_readn=1, FIFO pointers=0, count=0, empty=1, full=0, dout=0, overflow=0, hex_word=0. Reset mid-handshake aborts it; key_readn returns to 1 on the same edge.
- Handshake FSM, all outputs registered:
  - IDLE: when key_ready=1, take capture decision on key_code at this edge; next state ACK with key_readn=0.
  - ACK: exactly one cycle with key_readn=0; next state WAIT with key_readn=1.
  - WAIT: stay while key_ready=1; go to IDLE on the first cycle key_ready=0.
  - A still-high key_ready therefore never produces a second capture.
  - Min spacing between captures is 3 cycles.
- Capture decision:
  - Push if count<DEPTH, or if rd_en=1 with empty=0 on the same edge (pop frees a slot).
  - Otherwise drop the code, set overflow=1, and still acknowledge so the debounce stage never stalls.
- Pop:
  - rd_en=1 with empty=0 advances the read pointer; dout shows the next head in the following cycle.
  - rd_en while empty is ignored, with no underflow flag.
  - dout holds its last value when empty.
- Simultaneous push and pop: count is unchanged, both pointers advance. With count=1, dout updates to the new code next cycle and empty stays 0.
- Pointers wrap modulo DEPTH. Count is AW+1 bits: full = (count==DEPTH), empty = (count==0).
- Overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it on the next edge.
- Latency: key_ready rise at edge N → entry visible on dout/count after edge N+1 when the FIFO was empty.

Optional Feature:
Macro KEY_HEX_SHIFT_EN.
- Defined: on each accepted push whose code is 0x00–0x0F, hex_word <= {hex_word[27:0], code[3:0]}. Code 0x1F clears hex_word to 0. Other codes leave it unchanged. Dropped (overflow) codes never affect hex_word. Updates on the same edge as the FIFO write.
- Not defined: hex_word is constant 0 and no shift logic is synthesised. The FIFO and handshake behaviour are identical in both builds.

Test Plan:
1. Reset then idle 10 cycles → key_readn=1, empty=1, count=0, overflow=0, hex_word=0.
2. key_ready=1 with key_code=0x0A, held 6 cycles → key_readn low for exactly one cycle, one entry, dout=0x0A, count=1; drop key_ready, repeat with 0x05 → count=2, rd_en pops 0x0A then 0x05, then empty=1.
3. Push 8 codes 0x01..0x08 without reading, then 9th code 0x09 → ack still pulsed, count=8, full=1, overflow=1; pop all → 0x01..0x08 in order; clr_ovf → overflow=0.
4. FIFO full, 9th key capture edge coincides with rd_en=1 → code accepted, count stays 8, overflow stays 0, last pop yields the 9th code.
5. Assert rst during the ACK cycle → key_readn=1 on the next edge, FIFO empty, FSM IDLE; key_ready still high → new capture occurs after reset release.
6. (KEY_HEX_SHIFT_EN) push 0x01, 0x02, 0x0F, 0x14, 0x03 → hex_word=0x0000_012F then 0x0000_12F3; push 0x1F → hex_word=0; without macro hex_word stays 0 throughout.
